// File: rtl/periph_bus_master_if.sv
// Host request/response channels and peripheral bus signals of periph_bus_master.
// The master modport faces the bus master; slave faces the host and responders.
interface periph_bus_master_if #(
    parameter int unsigned NSLV = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_wr;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic [NSLV-1:0]      bus_cs;
    logic                 bus_wr;
    logic [31:0]          bus_addr;
    logic [31:0]          bus_wdata;
    logic [NSLV*32-1:0]   bus_rdata;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, bus_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               bus_cs, bus_wr, bus_addr, bus_wdata
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready, bus_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               bus_cs, bus_wr, bus_addr, bus_wdata
    );
endinterface

// File: rtl/periph_bus_master.sv
// Single-access initiator for the memory-mapped peripheral bus: decodes a host
// request into one chip-select, performs one bus cycle and returns the response.
module periph_bus_master #(
    parameter int unsigned NSLV      = 4,
    parameter logic [31:0] BASE      = 32'h4000_0000,
    parameter int unsigned SLOT_BITS = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    periph_bus_master_if.master  pb,
    output logic [7:0]           err_cnt
);
    localparam int unsigned SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned HI    = SLOT_BITS + $clog2(NSLV);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t             state, state_nxt;
    logic               wr_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [SEL_W-1:0]   slot_q;
    logic [31:0]        rdata_q;
    logic               err_q;

    logic               in_window;
    logic               misaligned;
    logic               dec_err;
    logic [SEL_W-1:0]   dec_slot;
    logic               accept;

    assign in_window  = (pb.req_addr >> HI) == (BASE >> HI);
    assign misaligned = |pb.req_addr[1:0];
    assign dec_err    = !in_window || misaligned;

    generate
        if (NSLV > 1) begin : g_slot
            assign dec_slot = pb.req_addr[SLOT_BITS +: SEL_W];
        end else begin : g_single
            assign dec_slot = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // bus_cs/bus_wr decode straight from state, so async reset drops them at once
    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        pb.req_ready = 1'b0;
        pb.rsp_valid = 1'b0;
        pb.bus_cs    = '0;
        pb.bus_wr    = 1'b0;
        case (state)
            IDLE: begin
                pb.req_ready = !reset;
                if (pb.req_valid) begin
                    accept    = 1'b1;
                    state_nxt = dec_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                pb.bus_cs = NSLV'(1) << slot_q;
                pb.bus_wr = wr_q;
                state_nxt = RESP;
            end
            RESP: begin
                pb.rsp_valid = 1'b1;
                if (pb.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            slot_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (accept) begin
                wr_q    <= pb.req_wr;
                addr_q  <= pb.req_addr;
                wdata_q <= pb.req_wdata;
                slot_q  <= dec_slot;
                if (dec_err) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end
            end
            if (state == ACCESS) begin
                rdata_q <= wr_q ? '0 : pb.bus_rdata[{slot_q, 5'b0} +: 32];
                err_q   <= 1'b0;
            end
        end
    end

    assign pb.bus_addr  = addr_q;
    assign pb.bus_wdata = wdata_q;
    assign pb.rsp_rdata = rdata_q;
    assign pb.rsp_err   = err_q;
endmodule

// File: doc/periph_bus_master.md
# periph_bus_master

- Bus initiator for the memory-mapped peripheral bus. GPIO and similar responders sit on the far end of this bus and expose `cs`/`wr`/`addr`/`wdata`/`rdata`.
- Accepts single read/write requests from a host-side source (command parser, debug port, CPU adapter) over a valid/ready handshake.
- Decodes the address into one of NSLV chip-selects and performs exactly one single-cycle bus access per request.
- Returns read data and an error flag over a valid/ready response channel.

## Interface
Parameters:
- NSLV, 4, number of responder slots; power of two, 1..16
- BASE, 32'h4000_0000, base address of the peripheral window; aligned to NSLV·2^SLOT_BITS
- SLOT_BITS, 12, log2 of bytes per responder slot (4 KB)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  host request present
- req_ready  out  1  master accepts request; high only in IDLE
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  host accepts response
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  decode/alignment error
- bus_cs  out  NSLV  one-hot chip-select, one bit per slot
- bus_wr  out  1  write strobe, qualified by bus_cs
- bus_addr  out  32  access address
- bus_wdata  out  32  write data
- bus_rdata  in  NSLV·32  flattened responder read data; slot k occupies bits [32k+31:32k]
- err_cnt  out  8  saturating count of errored requests

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE:** req_ready=1. When req_valid is high at a clk edge:
  - Latch req_wr, req_addr and req_wdata into registers that drive bus_wr, bus_addr and bus_wdata.
  - Evaluate decode.
- **Decode:**
  - in_window = (req_addr[31:SLOT_BITS+log2(NSLV)] == BASE[31:SLOT_BITS+log2(NSLV)]).
  - slot = req_addr[SLOT_BITS+log2(NSLV)-1:SLOT_BITS].
  - misaligned = (req_addr[1:0] != 0).
  - error = !in_window || misaligned.
- **On error:** go directly to RESP with rsp_err=1 and rsp_rdata=0. No bus_cs is asserted. err_cnt increments and saturates at 255.
- **Otherwise:** go to ACCESS.
- **ACCESS:** lasts exactly one cycle.
  - bus_cs[slot]=1, all other cs bits 0, bus_wr=latched wr.
  - At the closing edge, capture rsp_rdata from the bus_rdata slice of the selected slot on reads, or 0 on writes. Set rsp_err=0 and go to RESP.
- **RESP:** rsp_valid=1. rsp_rdata and rsp_err are held stable until the edge where rsp_ready=1, then go to IDLE.
- **Outside ACCESS:** bus_cs=0 and bus_wr=0. bus_addr and bus_wdata hold their last latched values.
- **No pipelining:** at most one transaction is outstanding.
- **Reset:** all outputs are 0 and the state is IDLE.
  - req_ready rises when reset deasserts, since it follows IDLE.
  - Reset asserted mid-transaction drops bus_cs and bus_wr immediately (async), discards any pending response, and clears err_cnt.

## Timing
- Request accepted at edge E0.
  - ACCESS occupies cycle E0→E1. The responder samples cs&wr at E1, so there is exactly one write.
  - rsp_valid is high from E1.
  - With rsp_ready held high, the response completes at E2, req_ready is high after E2, and the next request can be accepted at E3.
  - Minimum 3 cycles per transaction.
- Errored request: accepted at E0, rsp_valid high from E0, completes at E1 at the earliest. err_cnt updates at E0.
- req_ready is a combinational decode of state==IDLE and does not depend on req_valid.
- bus_addr and bus_wdata are stable during the whole ACCESS cycle.
- rsp_rdata reflects the selected bus_rdata slice as sampled at the E1 edge. Later changes on bus_rdata do not affect it.
- Backpressure: while rsp_valid=1 && rsp_ready=0, all rsp_* outputs are held and req_ready=0.

## Test plan
- **Write to slot 0:** req_wr=1, addr=32'h4000_0000, wdata=32'h0000_00FF.
  - bus_cs=4'b0001 and bus_wr=1 for exactly one cycle, bus_wdata=32'hFF.
  - rsp_err=0, rsp_rdata=0.
- **Read from slot 2:** req_wr=0, addr=32'h4000_2008, slot 2 data=32'hA5.
  - bus_cs=4'b0100 and bus_wr=0 for one cycle, bus_addr=32'h4000_2008.
  - rsp_rdata=32'hA5, rsp_err=0.
- **Out-of-window and misaligned:**
  - addr=32'h0000_0010 → bus_cs never asserts, rsp_err=1, err_cnt=1.
  - Then addr=32'h4000_0002 → rsp_err=1, err_cnt=2.
- **Backpressure:** read with rsp_ready=0 for 5 cycles.
  - rsp_valid, rsp_rdata and rsp_err stay stable; req_ready stays 0; no extra bus_cs pulses.
  - Release rsp_ready → IDLE one edge later.
- **Back-to-back and saturation:**
  - 300 erroring requests with rsp_ready=1 → err_cnt stops at 255.
  - Subsequent valid writes still produce exactly one cs pulse each, 3 cycles apart.
- **Reset mid-access:** assert reset during ACCESS.
  - bus_cs and bus_wr fall to 0 before the next edge; rsp_valid=0; err_cnt=0.
  - req_ready=1 after release; a fresh request completes normally.
